// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with fill level, threshold flags, sticky error flags, synchronous flush and registered read port.
// Define SYNC_FIFO_PARITY_EN to store an even-parity bit per word and raise parity_err on a mismatching read.
module sync_fifo_ctl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr,
  output logic                  parity_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL    = (ADDR_WIDTH+1)'(AE_THRESH);

`ifdef SYNC_FIFO_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  logic [MEM_W-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level_q;
  logic [MEM_W-1:0]      wr_word;
  logic [MEM_W-1:0]      rd_word;
  logic                  wr_acc;
  logic                  rd_acc;

  assign level        = level_q;
  assign full         = (level_q == DEPTH_LVL);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= AF_LVL);
  assign almost_empty = (level_q <= AE_LVL);

  // Flush swallows same-cycle requests, so they neither move data nor raise errors.
  assign wr_acc  = wr_en && !full && !flush;
  assign rd_acc  = rd_en && !empty && !flush;
  assign rd_word = mem[rd_ptr];

`ifdef SYNC_FIFO_PARITY_EN
  assign wr_word = {^wr_data, wr_data};
`else
  assign wr_word = wr_data;
`endif

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // rd_data keeps its last word whenever no read is accepted, including across a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= rd_word[DATA_WIDTH-1:0];
    end
  end

  // A new error in the same cycle as err_clr must win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !flush) overflow <= 1'b1;
      else if (err_clr)            overflow <= 1'b0;
      if (rd_en && empty && !flush) underflow <= 1'b1;
      else if (err_clr)             underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_PARITY_EN
  logic par_bad;
  assign par_bad = rd_acc && ((^rd_word[DATA_WIDTH-1:0]) != rd_word[DATA_WIDTH]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          parity_err <= 1'b0;
    else if (par_bad) parity_err <= 1'b1;
    else if (err_clr) parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Scoreboard bench for sync_fifo_ctl: a queue model predicts flags and errors, read data is popped from an expect queue.
module tb_sync_fifo_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;
  logic       err_clr;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  // Model: bit 8 of each entry marks a word whose stored parity was corrupted.
  logic [8:0] model_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rd_data_m;
  logic       rd_valid_m;
  logic       ov_m;
  logic       un_m;
  logic       par_m;

  sync_fifo_ctl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .AF_THRESH (14),
    .AE_THRESH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow),
    .err_clr     (err_clr),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    model_q.delete();
    exp_q.delete();
    rd_data_m  = '0;
    rd_valid_m = 1'b0;
    ov_m       = 1'b0;
    un_m       = 1'b0;
    par_m      = 1'b0;
  endtask

  task automatic checkState();
    int sz;
    sz = model_q.size();
    checkOutput("level", 32'(level), 32'(sz));
    checkOutput("full", 32'(full), 32'(sz == 16));
    checkOutput("empty", 32'(empty), 32'(sz == 0));
    checkOutput("almost_full", 32'(almost_full), 32'(sz >= 14));
    checkOutput("almost_empty", 32'(almost_empty), 32'(sz <= 2));
    checkOutput("overflow", 32'(overflow), 32'(ov_m));
    checkOutput("underflow", 32'(underflow), 32'(un_m));
    checkOutput("parity_err", 32'(parity_err), 32'(par_m));
    checkOutput("rd_valid", 32'(rd_valid), 32'(rd_valid_m));
    checkOutput("rd_data_hold", 32'(rd_data), 32'(rd_data_m));
  endtask

  // Drive one cycle of requests, advance the model, then check after the edge.
  task automatic applyStimulus(input logic wr, input logic [7:0] wd, input logic rd,
                               input logic fl, input logic clr);
    logic full_m, empty_m, wacc, racc;
    logic [8:0] word;
    wr_en   = wr;
    wr_data = wd;
    rd_en   = rd;
    flush   = fl;
    err_clr = clr;
    full_m  = (model_q.size() == 16);
    empty_m = (model_q.size() == 0);
    wacc    = wr && !full_m && !fl;
    racc    = rd && !empty_m && !fl;
    rd_valid_m = racc;
    if (!fl && wr && full_m) ov_m = 1'b1;
    else if (clr)            ov_m = 1'b0;
    if (!fl && rd && empty_m) un_m = 1'b1;
    else if (clr)             un_m = 1'b0;
    if (fl) begin
      model_q.delete();
      if (clr) par_m = 1'b0;
    end else begin
      if (racc) begin
        word = model_q.pop_front();
        exp_q.push_back(word[7:0]);
        rd_data_m = word[7:0];
        if (word[8])  par_m = 1'b1;
        else if (clr) par_m = 1'b0;
      end else if (clr) begin
        par_m = 1'b0;
      end
      if (wacc) model_q.push_back({1'b0, wd});
    end
    @(posedge clk);
    #1;
    if (rd_valid) begin
      if (exp_q.size() == 0) checkOutput("rd_valid_spurious", 32'(rd_valid), 32'd0);
      else checkOutput("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
    checkState();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    flush   = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkState();
    rst = 1'b0;

    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Fill to full, then one overflowing write.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);

    // Drain back-to-back, then one underflowing read.
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Wrap-around of both pointers.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Streaming at level 5.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'h70 + 8'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Simultaneous at full: read wins, write overflows.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Simultaneous at empty: write wins, read underflows.
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Flush at level 7 with a same-cycle write.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Flush at full with both requests: sticky overflow survives, no new errors.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hDE, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    resetModel();
    checkState();
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkState();

`ifdef SYNC_FIFO_PARITY_EN
    // Corrupt the stored parity bit of the next word; data must still come through.
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    dut.mem[0][8] = ~dut.mem[0][8];
    model_q[0][8] = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`endif

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
